// File: rtl/tdiv_seq.sv
// Sequential balanced-ternary divider: ternary->binary Horner, restoring binary divide, binary->ternary.
// Latency 2*TRITS+MAGW+3 cycles normally, TRITS+2 on error; start is ignored while an operation is in flight.
module tdiv_seq #(
    parameter int TRITS = 6,
    parameter int MAGW  = 10
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [2*TRITS-1:0]   a,
    input  logic [2*TRITS-1:0]   b,
    output logic                 busy,
    output logic                 done,
    output logic [2*TRITS-1:0]   q,
    output logic [2*TRITS-1:0]   r,
    output logic                 err
);
    localparam int W  = 2 * TRITS;
    localparam int CW = $clog2(MAGW + 1);

    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] CONV  = 3'd1;
    localparam logic [2:0] CHECK = 3'd2;
    localparam logic [2:0] DIV   = 3'd3;
    localparam logic [2:0] SIGN  = 3'd4;
    localparam logic [2:0] BACK  = 3'd5;
    localparam logic [2:0] DONE  = 3'd6;

    localparam logic signed [MAGW:0] ONE   = (MAGW+1)'(1);
    localparam logic signed [MAGW:0] THREE = (MAGW+1)'(3);

    logic [2:0]               state;
    logic [CW-1:0]            cnt;
    logic [W-1:0]             a_sh, b_sh;
    logic signed [MAGW:0]     a_acc, b_acc;
    logic                     inv;
    logic                     neg_a, neg_b;
    logic [MAGW-1:0]          quo, rem, divs;
    logic signed [MAGW:0]     qv, rv;
    logic [W-1:0]             qt, rt;

    function automatic logic signed [MAGW:0] trit_val(input logic [1:0] t);
        case (t)
            2'b10:   trit_val = ONE;
            2'b01:   trit_val = -ONE;
            default: trit_val = '0;
        endcase
    endfunction

    // Returns {trit code, (v - t)/3} for one balanced-ternary digit, LSB first.
    function automatic logic [MAGW+2:0] bt_step(input logic signed [MAGW:0] v);
        logic signed [MAGW:0] m;
        logic signed [MAGW:0] t;
        logic signed [MAGW:0] nx;
        logic [1:0]           c;
        m = v % THREE;
        if (m < 0)
            m = m + THREE;
        if (m == 0) begin
            t = '0;
            c = 2'b00;
        end else if (m == ONE) begin
            t = ONE;
            c = 2'b10;
        end else begin
            t = -ONE;
            c = 2'b01;
        end
        nx = (v - t) / THREE;
        bt_step = {c, nx};
    endfunction

    logic [MAGW-1:0]      abs_a, abs_b;
    logic [MAGW:0]        trial;
    logic                 ge;
    logic [MAGW-1:0]      rem_nx;
    logic signed [MAGW:0] qpos, rpos;
    logic [MAGW+2:0]      sq, sr;
    logic [W-1:0]         qt_nx, rt_nx;

    always_comb begin
        abs_a  = a_acc[MAGW] ? MAGW'(-a_acc) : a_acc[MAGW-1:0];
        abs_b  = b_acc[MAGW] ? MAGW'(-b_acc) : b_acc[MAGW-1:0];
        trial  = {rem, quo[MAGW-1]};
        ge     = trial >= {1'b0, divs};
        rem_nx = ge ? MAGW'(trial - {1'b0, divs}) : trial[MAGW-1:0];
        qpos   = $signed({1'b0, quo});
        rpos   = $signed({1'b0, rem});
        sq     = bt_step(qv);
        sr     = bt_step(rv);
        qt_nx  = {sq[MAGW+2:MAGW+1], qt[W-1:2]};
        rt_nx  = {sr[MAGW+2:MAGW+1], rt[W-1:2]};
    end

    assign busy = (state != IDLE) && (state != DONE);
    assign done = (state == DONE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
            a_sh  <= '0;
            b_sh  <= '0;
            a_acc <= '0;
            b_acc <= '0;
            inv   <= 1'b0;
            neg_a <= 1'b0;
            neg_b <= 1'b0;
            quo   <= '0;
            rem   <= '0;
            divs  <= '0;
            qv    <= '0;
            rv    <= '0;
            qt    <= '0;
            rt    <= '0;
            q     <= '0;
            r     <= '0;
            err   <= 1'b0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    a_sh  <= a;
                    b_sh  <= b;
                    a_acc <= '0;
                    b_acc <= '0;
                    inv   <= 1'b0;
                    cnt   <= '0;
                    state <= CONV;
                end
                CONV: begin
                    a_acc <= a_acc * THREE + trit_val(a_sh[W-1:W-2]);
                    b_acc <= b_acc * THREE + trit_val(b_sh[W-1:W-2]);
                    inv   <= inv | (&a_sh[W-1:W-2]) | (&b_sh[W-1:W-2]);
                    a_sh  <= a_sh << 2;
                    b_sh  <= b_sh << 2;
                    cnt   <= cnt + 1'b1;
                    if (cnt == CW'(TRITS - 1))
                        state <= CHECK;
                end
                CHECK: begin
                    if (inv || b_acc == '0) begin
                        q     <= '0;
                        r     <= '0;
                        err   <= 1'b1;
                        state <= DONE;
                    end else begin
                        neg_a <= a_acc[MAGW];
                        neg_b <= b_acc[MAGW];
                        quo   <= abs_a;
                        divs  <= abs_b;
                        rem   <= '0;
                        cnt   <= '0;
                        state <= DIV;
                    end
                end
                DIV: begin
                    rem <= rem_nx;
                    quo <= {quo[MAGW-2:0], ge};
                    cnt <= cnt + 1'b1;
                    if (cnt == CW'(MAGW - 1))
                        state <= SIGN;
                end
                SIGN: begin
                    // Negating zero stays zero, so results are never -0.
                    qv    <= (neg_a ^ neg_b) ? -qpos : qpos;
                    rv    <= neg_a ? -rpos : rpos;
                    qt    <= '0;
                    rt    <= '0;
                    cnt   <= '0;
                    state <= BACK;
                end
                BACK: begin
                    qv  <= $signed(sq[MAGW:0]);
                    rv  <= $signed(sr[MAGW:0]);
                    qt  <= qt_nx;
                    rt  <= rt_nx;
                    cnt <= cnt + 1'b1;
                    if (cnt == CW'(TRITS - 1)) begin
                        q     <= qt_nx;
                        r     <= rt_nx;
                        err   <= 1'b0;
                        state <= DONE;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_tdiv_seq.sv
// Self-checking bench for tdiv_seq: vector table, handshake/reset corner sequences, random ops vs integer model.
module tb_tdiv_seq;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [11:0] a = '0, b = '0;
    logic        busy, done, err;
    logic [11:0] q, r;

    int errors = 0;
    int checks = 0;

    tdiv_seq #(.TRITS(6), .MAGW(10)) dut (
        .clk(clk), .rst(rst), .start(start), .a(a), .b(b),
        .busy(busy), .done(done), .q(q), .r(r), .err(err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [11:0] va;
        logic [11:0] vb;
        int          eq;
        int          er;
        int          eerr;
    } vec_t;

    vec_t tv[12];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic logic [11:0] enc(input int v);
        logic [11:0] w;
        int x, m;
        w = '0;
        x = v;
        for (int i = 0; i < 6; i++) begin
            m = ((x % 3) + 3) % 3;
            if (m == 1) begin
                w[2*i +: 2] = 2'b10;
                x = (x - 1) / 3;
            end else if (m == 2) begin
                w[2*i +: 2] = 2'b01;
                x = (x + 1) / 3;
            end else begin
                x = x / 3;
            end
        end
        return w;
    endfunction

    function automatic int dec(input logic [11:0] w);
        int v;
        v = 0;
        for (int i = 5; i >= 0; i--) begin
            v = v * 3;
            if (w[2*i +: 2] == 2'b10) v = v + 1;
            else if (w[2*i +: 2] == 2'b01) v = v - 1;
        end
        return v;
    endfunction

    function automatic int has_inv(input logic [11:0] w);
        int f;
        f = 0;
        for (int i = 0; i < 6; i++)
            if (w[2*i +: 2] == 2'b11) f = 1;
        return f;
    endfunction

    // Issues one operation from IDLE and returns the cycle index at which done was seen (-1 on timeout).
    task automatic run_op(input logic [11:0] va, input logic [11:0] vb, output int lat, output int busy_ok);
        int c;
        a = va;
        b = vb;
        start = 1'b1;
        tick();
        start = 1'b0;
        c = 1;
        lat = -1;
        busy_ok = busy ? 1 : 0;
        while (c < 100) begin
            tick();
            c++;
            if (done) begin
                lat = c;
                break;
            end
            if (!busy) busy_ok = 0;
        end
        if (lat < 0) begin
            errors++;
            $display("FAIL timeout: done not seen within 100 cycles");
        end
    endtask

    task automatic check_result(input string tag, input int eq, input int er, input int eerr, input int lat, input int busy_ok);
        check({tag, "_lat"}, lat, (eerr != 0) ? 8 : 25);
        check({tag, "_busy"}, busy_ok, 1);
        check({tag, "_err"}, int'(err), eerr);
        check({tag, "_q"}, dec(q), eq);
        check({tag, "_r"}, dec(r), er);
        check({tag, "_trits"}, has_inv(q) + has_inv(r), 0);
    endtask

    initial begin
        int lat, bok, cnt_done, c, ai, bi, eq, er, ee;
        int dpos[3];
        logic [11:0] tmp;

        tv[0]  = '{12'b00_00_00_10_01_10, 12'b00_00_00_00_10_01, 3, 1, 0};
        tv[1]  = '{enc(-7),   enc(2),    -3,  -1, 0};
        tv[2]  = '{enc(7),    enc(-2),   -3,   1, 0};
        tv[3]  = '{enc(-364), enc(-1),   364,  0, 0};
        tv[4]  = '{enc(7),    enc(0),     0,   0, 1};
        tmp = enc(5);
        tmp[7:6] = 2'b11;
        tv[5]  = '{tmp,       enc(2),     0,   0, 1};
        tv[6]  = '{enc(6),    enc(3),     2,   0, 0};
        tv[7]  = '{enc(0),    enc(5),     0,   0, 0};
        tv[8]  = '{enc(5),    enc(7),     0,   5, 0};
        tv[9]  = '{enc(364),  enc(-364), -1,   0, 0};
        tv[10] = '{enc(-100), enc(7),   -14,  -2, 0};
        tv[11] = '{enc(363),  enc(-2), -181,   1, 0};

        // Reset and idle behaviour
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        check("rst_err", int'(err), 0);
        check("rst_q", int'(q), 0);
        check("rst_r", int'(r), 0);
        cnt_done = 0;
        for (int i = 0; i < 30; i++) begin
            tick();
            if (done) cnt_done++;
        end
        check("idle_no_done", cnt_done, 0);

        // Vector table
        for (int i = 0; i < 12; i++) begin
            run_op(tv[i].va, tv[i].vb, lat, bok);
            check_result($sformatf("vec%0d", i), tv[i].eq, tv[i].er, tv[i].eerr, lat, bok);
            if (i == 0) begin
                check("q_raw_7_2", int'(q), int'(12'b00_00_00_00_10_00));
                check("r_raw_7_2", int'(r), int'(12'b00_00_00_00_00_10));
            end
            tick();
        end

        // start pulsed mid-operation is ignored
        a = enc(7);
        b = enc(2);
        start = 1'b1;
        tick();
        start = 1'b0;
        cnt_done = 0;
        for (c = 1; c < 60; c++) begin
            if (c == 10) begin
                a = enc(100);
                b = enc(3);
                start = 1'b1;
            end else begin
                start = 1'b0;
            end
            tick();
            if (done) cnt_done++;
        end
        start = 1'b0;
        check("midstart_done_count", cnt_done, 1);
        check("midstart_q", dec(q), 3);
        check("midstart_r", dec(r), 1);

        // start held high: back-to-back operations
        a = enc(-7);
        b = enc(2);
        start = 1'b1;
        cnt_done = 0;
        for (c = 0; c < 90 && cnt_done < 3; c++) begin
            tick();
            if (done) begin
                dpos[cnt_done] = c;
                cnt_done++;
            end
        end
        start = 1'b0;
        check("b2b_done_count", cnt_done, 3);
        if (cnt_done == 3) begin
            check("b2b_gap1", dpos[1] - dpos[0], 26);
            check("b2b_gap2", dpos[2] - dpos[1], 26);
        end
        check("b2b_q", dec(q), -3);
        tick();
        tick();

        // Reset mid-DIV
        a = enc(7);
        b = enc(2);
        start = 1'b1;
        tick();
        start = 1'b0;
        for (c = 1; c < 12; c++) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("midrst_busy", int'(busy), 0);
        check("midrst_q", int'(q), 0);
        check("midrst_r", int'(r), 0);
        cnt_done = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (done) cnt_done++;
        end
        check("midrst_no_done", cnt_done, 0);
        run_op(enc(7), enc(2), lat, bok);
        check_result("after_rst", 3, 1, 0, lat, bok);
        tick();

        // Random operations against integer model
        for (int n = 0; n < 150; n++) begin
            ai = int'($urandom_range(728)) - 364;
            bi = ($urandom_range(15) == 0) ? 0 : int'($urandom_range(728)) - 364;
            if (bi == 0) begin
                eq = 0; er = 0; ee = 1;
            end else begin
                eq = ai / bi; er = ai % bi; ee = 0;
            end
            run_op(enc(ai), enc(bi), lat, bok);
            check_result($sformatf("rnd%0d_%0d_%0d", n, ai, bi), eq, er, ee, lat, bok);
            tick();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/tdiv_seq.md
Name: tdiv_seq

Overview:
- Sequential balanced-ternary word divider: the inverse operation of the single-trit multiplier (MUL_TE) in the ternary ALU.
- Takes an N-trit dividend and divisor; returns quotient (truncated toward zero) and remainder.
- Computes via internal ternary->binary conversion, restoring binary division, then binary->ternary conversion.
- Sits beside the multiplier in the execute stage; start/done handshake.

Parameters:
- TRITS, 6, trits per operand/result word.
- MAGW, 10, binary magnitude width; must satisfy 2^MAGW > (3^TRITS-1)/2.

Ports:
- clk  input  1  clock, rising edge
- rst  input  1  synchronous reset, active-high
- start  input  1  request; sampled only in IDLE
- a  input  2*TRITS  dividend; trit i at [2i+1:2i], trit 0 = least significant
- b  input  2*TRITS  divisor, same layout
- busy  output  1  high from the cycle after start is accepted until done
- done  output  1  one-cycle pulse: results valid
- q  output  2*TRITS  quotient
- r  output  2*TRITS  remainder
- err  output  1  valid with done: divide-by-zero or invalid trit

Behaviour:
- Trit encoding: 2'b10 = +1, 2'b00 = 0, 2'b01 = -1, 2'b11 = invalid.
- Reset: state IDLE; busy=0, done=0, err=0, q and r all 2'b00.
- Reset mid-operation: abort immediately; no done pulse is issued.
- start with state=IDLE: latch a and b; go to CONV. start in any other state is ignored.
- CONV, TRITS cycles:
  - Horner evaluation, MSB trit first: acc = acc*3 + t, both operands in parallel. Signed width MAGW+1.
  - Set a sticky invalid flag on any 2'b11 trit.
- CHECK, 1 cycle:
  - If invalid flag or divisor == 0: go to DONE with err=1, q=r=all 2'b00.
  - Otherwise take magnitudes, record signs, go to DIV.
- DIV, MAGW cycles: restoring division on magnitudes, one quotient bit per cycle, MSB first.
- SIGN, 1 cycle: quotient sign = sign(a) XOR sign(b); remainder sign = sign(a). Zero results are never negative.
- BACK, TRITS cycles:
  - Binary->balanced ternary, LSB first: t = v mod 3 mapped {0->0, 1->+1, 2->-1}; v = (v - t)/3.
  - Quotient and remainder convert in parallel, shifted into result registers.
- DONE, 1 cycle: update q, r, err; done=1, busy=0; return to IDLE.
- A new start is accepted in the cycle after DONE.
- Latency, counted in cycles from the start-accept edge to the cycle done is high:
  - Normal path: TRITS+1+MAGW+1+TRITS+1 = 2*TRITS+MAGW+3 (25 for defaults).
  - Error path: TRITS+2 (8).
- q, r and err hold their values until the next DONE; they do not change while busy.
- Invariant for any legal operands: a = q*b + r, |r| < |b|, sign(r) = sign(a) or r = 0.
- Ranges: q in [-364, 364]; r in [-363, 363] (TRITS=6). No overflow is possible.

Test Plan:
- Reset then idle: rst high 2 cycles -> busy=0, done=0, err=0, q=r=0. start held low -> done never pulses.
- 7 / 2: a = 0,0,0,+,-,+ (MSB..LSB), b = 0,0,0,0,+,-.
  - q = 3 (0,0,0,0,+,0), r = 1 (...,0,+), err=0.
  - done exactly 25 cycles after start accept; busy high throughout.
- Signs: -7 / 2 -> q = -3, r = -1. 7 / -2 -> q = -3, r = +1. -364 / -1 -> q = +364 (all +), r = 0.
- Errors:
  - b = 0 -> err=1, q=r=0, done 8 cycles after start.
  - a with trit 3 = 2'b11 -> err=1.
  - Next valid op (6/3 -> q=2, r=0) clears err.
- Handshake:
  - start pulsed again mid-operation -> ignored; exactly one done, results unchanged.
  - start high continuously -> back-to-back ops, done every 26 cycles.
- Reset mid-DIV: rst asserted at cycle 12 -> no done pulse, busy=0, outputs zero; a fresh 7/2 then completes correctly.
